lfsr_sequence_checker: RTL

//  Downstream consumer of the 4-bit LFSR generator output. Samples the LFSR word, predicts each next

---
 rtl/lfsr_pkg.sv | 25 ++
 rtl/lfsr_period_meter.sv | 57 +++++
 rtl/lfsr_sequence_checker.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/lfsr_pkg.sv
`default_nettype none
// ============================================================================
// lfsr_pkg: checker state encoding and the shared LFSR polynomial step.
// Rev 1.0
// ============================================================================
package lfsr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACQ    = 2'd1,
    ST_LOCKED = 2'd2,
    ST_ZERO   = 2'd3
  } chk_state_e;

  localparam logic [3:0] DEFAULT_TAPS = 4'b1100;
  localparam int         LFSR_FN_W    = 32;

  // Callers zero-extend cur/taps and keep the low WIDTH bits of the result.
  function automatic logic [LFSR_FN_W-1:0] lfsr_next(input logic [LFSR_FN_W-1:0] cur,
                                                     input logic [LFSR_FN_W-1:0] taps);
    return {cur[LFSR_FN_W-2:0], ^(cur & taps)};
  endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr_period_meter.sv
`default_nettype none
// ============================================================================
// lfsr_period_meter: counts samples between recurrences of a reference word.
// Rev 1.0
// ============================================================================
module lfsr_period_meter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] sample_i,
  output logic [WIDTH-1:0] period_o,
  output logic             period_valid_o
);

  logic [WIDTH-1:0] ref_q;
  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] period_q;
  logic             period_valid_q;
  logic [WIDTH-1:0] cnt_inc;

  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      ref_q          <= '0;
      cnt_q          <= '0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
    end else if (load_i) begin
      ref_q          <= sample_i;
      cnt_q          <= '0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
    end else if (!en_i) begin
      cnt_q          <= '0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
    end else if (step_i) begin
      if (sample_i == ref_q) begin
        period_q       <= cnt_inc;
        period_valid_q <= 1'b1;
        cnt_q          <= '0;
      end else begin
        cnt_q <= cnt_inc;
      end
    end
  end

  assign period_o       = period_q;
  assign period_valid_o = period_valid_q;

endmodule
`default_nettype wire

// File: rtl/lfsr_sequence_checker.sv
`default_nettype none
// ============================================================================
// lfsr_sequence_checker: locks onto an LFSR stream, flags errors and lock-up.
// Rev 1.0
// ============================================================================
module lfsr_sequence_checker
  import lfsr_pkg::*;
#(
  parameter int               WIDTH      = 4,
  parameter logic [WIDTH-1:0] TAP_MASK   = WIDTH'(DEFAULT_TAPS),
  parameter int               LOCK_COUNT = 4,
  parameter int               CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] lfsr_in,
  input  logic             lfsr_valid,
  input  logic             clr_err,
  output logic             locked,
  output logic             error,
  output logic [CNT_W-1:0] err_count,
  output logic             stuck_zero,
  output logic [WIDTH-1:0] period,
  output logic             period_valid
);

  localparam int               MC_W    = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT);
  localparam logic [MC_W-1:0]  MC_LAST = MC_W'(LOCK_COUNT - 1);

  chk_state_e       state_q;
  logic [WIDTH-1:0] pred_q;
  logic [WIDTH-1:0] pred_d;
  logic [MC_W-1:0]  match_cnt_q;
  logic             locked_q;
  logic             error_q;
  logic             stuck_zero_q;
  logic [CNT_W-1:0] err_count_q;
  logic [CNT_W-1:0] err_count_d;

  logic [LFSR_FN_W-1:0]       next_full;
  logic [LFSR_FN_W-1:WIDTH]   next_unused;
  logic                       sample_zero;
  logic                       sample_hit;
  logic                       lock_hit;
  logic                       lock_drop;
  logic                       meter_en;

  assign next_full   = lfsr_next(LFSR_FN_W'(lfsr_in), LFSR_FN_W'(TAP_MASK));
  assign pred_d      = next_full[WIDTH-1:0];
  assign next_unused = next_full[LFSR_FN_W-1:WIDTH];

  assign sample_zero = (lfsr_in == '0);
  assign sample_hit  = (lfsr_in == pred_q);
  assign lock_hit    = lfsr_valid && (state_q == ST_ACQ) && !sample_zero
                       && sample_hit && (match_cnt_q == MC_LAST);
  // Any departure from LOCKED on a valid sample is a counted sequence error.
  assign lock_drop   = lfsr_valid && (state_q == ST_LOCKED) && (sample_zero || !sample_hit);
  assign meter_en    = (state_q == ST_LOCKED) && !lock_drop;

  always_comb begin
    err_count_d = err_count_q;
    if (clr_err)
      err_count_d = '0;
    else if (lock_drop && !(&err_count_q))
      err_count_d = err_count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      pred_q       <= '0;
      match_cnt_q  <= '0;
      locked_q     <= 1'b0;
      error_q      <= 1'b0;
      stuck_zero_q <= 1'b0;
      err_count_q  <= '0;
    end else begin
      err_count_q <= err_count_d;
      error_q     <= lock_drop;
      if (lfsr_valid && sample_zero)
        stuck_zero_q <= 1'b1;
      else if (clr_err)
        stuck_zero_q <= 1'b0;

      if (lfsr_valid) begin
        pred_q <= pred_d;
        if (sample_zero) begin
          state_q     <= ST_ZERO;
          locked_q    <= 1'b0;
          match_cnt_q <= '0;
        end else begin
          unique case (state_q)
            ST_IDLE, ST_ZERO: begin
              state_q     <= ST_ACQ;
              match_cnt_q <= '0;
            end
            ST_ACQ: begin
              if (lock_hit) begin
                state_q     <= ST_LOCKED;
                locked_q    <= 1'b1;
                match_cnt_q <= '0;
              end else if (sample_hit) begin
                match_cnt_q <= match_cnt_q + 1'b1;
              end else begin
                match_cnt_q <= '0;
              end
            end
            ST_LOCKED: begin
              if (!sample_hit) begin
                state_q     <= ST_ACQ;
                locked_q    <= 1'b0;
                match_cnt_q <= '0;
              end
            end
            default: state_q <= ST_IDLE;
          endcase
        end
      end
    end
  end

  lfsr_period_meter #(
    .WIDTH (WIDTH)
  ) u_period_meter (
    .clk            (clk),
    .rst            (rst),
    .en_i           (meter_en),
    .load_i         (lock_hit),
    .step_i         (lfsr_valid),
    .sample_i       (lfsr_in),
    .period_o       (period),
    .period_valid_o (period_valid)
  );

  assign locked     = locked_q;
  assign error      = error_q;
  assign err_count  = err_count_q;
  assign stuck_zero = stuck_zero_q;

endmodule
`default_nettype wire
